// File: rtl/stm_timer.sv
// Two-segment STM index timer: each segment divides CLK into index steps and
// wraps its index at a programmable modulus, with shadowed settings and SYNC realignment.
module stm_timer_seg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        update,
   input  logic        sync,
   input  logic [15:0] cycle_in,
   input  logic [15:0] div_in,
   output logic [15:0] idx,
   output logic        wrap
);
   logic [15:0] presc_q, presc_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] act_cycle_q, act_cycle_d;
   logic [15:0] act_div_q, act_div_d;
   logic [15:0] sh_cycle_q, sh_cycle_d;
   logic [15:0] sh_div_q, sh_div_d;
   logic        pend_q, pend_d;
   logic        wrap_q, wrap_d;
   logic [15:0] eff_div, eff_cycle;
   logic        tick, at_end;

   always_comb begin
      eff_div     = (act_div_q == 16'd0) ? 16'd1 : act_div_q;
      eff_cycle   = (act_cycle_q == 16'd0) ? 16'd1 : act_cycle_q;
      // >= keeps the step well-defined even if the prescaler ever exceeds the divisor
      tick        = (presc_q >= eff_div - 16'd1);
      at_end      = (idx_q >= eff_cycle - 16'd1);
      presc_d     = presc_q;
      idx_d       = idx_q;
      act_cycle_d = act_cycle_q;
      act_div_d   = act_div_q;
      sh_cycle_d  = sh_cycle_q;
      sh_div_d    = sh_div_q;
      pend_d      = pend_q;
      wrap_d      = 1'b0;
      if (sync) begin
         presc_d = 16'd0;
         idx_d   = 16'd0;
         pend_d  = 1'b0;
         if (update) begin
            sh_cycle_d  = cycle_in;
            sh_div_d    = div_in;
            act_cycle_d = cycle_in;
            act_div_d   = div_in;
         end else if (pend_q) begin
            act_cycle_d = sh_cycle_q;
            act_div_d   = sh_div_q;
         end
      end else begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
         if (tick) begin
            if (at_end) begin
               idx_d  = 16'd0;
               wrap_d = 1'b1;
               if (pend_q) begin
                  act_cycle_d = sh_cycle_q;
                  act_div_d   = sh_div_q;
                  pend_d      = 1'b0;
               end
            end else begin
               idx_d = idx_q + 16'd1;
            end
         end
         // an update landing on a wrap edge stays pending for the following wrap
         if (update) begin
            sh_cycle_d = cycle_in;
            sh_div_d   = div_in;
            pend_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= 16'd0;
         idx_q       <= 16'd0;
         act_cycle_q <= 16'd1;
         act_div_q   <= 16'd1;
         sh_cycle_q  <= 16'd1;
         sh_div_q    <= 16'd1;
         pend_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         act_cycle_q <= act_cycle_d;
         act_div_q   <= act_div_d;
         sh_cycle_q  <= sh_cycle_d;
         sh_div_q    <= sh_div_d;
         pend_q      <= pend_d;
         wrap_q      <= wrap_d;
      end
   end

   assign idx  = idx_q;
   assign wrap = wrap_q;
endmodule

module stm_timer (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        UPDATE_SETTINGS,
   input  logic [15:0] CYCLE_0,
   input  logic [15:0] CYCLE_1,
   input  logic [15:0] FREQ_DIV_0,
   input  logic [15:0] FREQ_DIV_1,
   input  logic        SYNC,
   output logic [15:0] IDX_0_OUT,
   output logic [15:0] IDX_1_OUT,
   output logic        WRAP_0,
   output logic        WRAP_1
);
   localparam int NUM_SEG = 2;

   logic [NUM_SEG-1:0][15:0] cycle_in, div_in, idx;
   logic [NUM_SEG-1:0]       wrap;

   assign cycle_in = {CYCLE_1, CYCLE_0};
   assign div_in   = {FREQ_DIV_1, FREQ_DIV_0};

   for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
      stm_timer_seg u_seg (
         .clk      (CLK),
         .rst_n    (RST_N),
         .update   (UPDATE_SETTINGS),
         .sync     (SYNC),
         .cycle_in (cycle_in[g]),
         .div_in   (div_in[g]),
         .idx      (idx[g]),
         .wrap     (wrap[g])
      );
   end

   assign IDX_0_OUT = idx[0];
   assign IDX_1_OUT = idx[1];
   assign WRAP_0    = wrap[0];
   assign WRAP_1    = wrap[1];
endmodule

// File: tb/tb_stm_timer.sv
// Directed bench for stm_timer: inputs driven and outputs sampled on the falling edge.
module tb_stm_timer;
   logic        CLK, RST_N, UPDATE_SETTINGS, SYNC;
   logic [15:0] CYCLE_0, CYCLE_1, FREQ_DIV_0, FREQ_DIV_1;
   logic [15:0] IDX_0_OUT, IDX_1_OUT;
   logic        WRAP_0, WRAP_1;
   int          checks, errors;

   stm_timer dut (
      .CLK(CLK), .RST_N(RST_N), .UPDATE_SETTINGS(UPDATE_SETTINGS),
      .CYCLE_0(CYCLE_0), .CYCLE_1(CYCLE_1),
      .FREQ_DIV_0(FREQ_DIV_0), .FREQ_DIV_1(FREQ_DIV_1),
      .SYNC(SYNC),
      .IDX_0_OUT(IDX_0_OUT), .IDX_1_OUT(IDX_1_OUT),
      .WRAP_0(WRAP_0), .WRAP_1(WRAP_1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic load_sync(input logic [15:0] c0, input logic [15:0] d0);
      CYCLE_0 = c0; FREQ_DIV_0 = d0; CYCLE_1 = 16'd3; FREQ_DIV_1 = 16'd5;
      UPDATE_SETTINGS = 1'b1; SYNC = 1'b1;
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b0; SYNC = 1'b0;
   endtask

   task automatic test_reset;
      RST_N = 1'b0; UPDATE_SETTINGS = 1'b0; SYNC = 1'b0;
      CYCLE_0 = 16'd9; CYCLE_1 = 16'd9; FREQ_DIV_0 = 16'd9; FREQ_DIV_1 = 16'd9;
      #3;
      checks++;
      if ({IDX_0_OUT, IDX_1_OUT, WRAP_0, WRAP_1} !== 34'd0) begin
         errors++;
         $display("FAIL reset_state: got %h/%h/%b/%b want 0/0/0/0", IDX_0_OUT, IDX_1_OUT, WRAP_0, WRAP_1);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      // defaults cycle=1 div=1: index pinned at 0, wrap every cycle, inputs ignored without update
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if ({IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1} !== {16'd0, 1'b1, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_default c%0d: got %h/%b %h/%b want 0/1 0/1", i, IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1);
         end
      end
   endtask

   task automatic test_sync_update;
      logic [15:0] e0, e1;
      logic        w0, w1;
      load_sync(16'd4, 16'd1);
      checks++;
      if ({IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1} !== 34'd0) begin
         errors++;
         $display("FAIL sync_update_k0: got %h/%b %h/%b want 0/0 0/0", IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1);
      end
      for (int k = 1; k <= 30; k++) begin
         @(negedge CLK);
         e0 = 16'(k % 4);
         w0 = (k % 4 == 0);
         e1 = 16'((k / 5) % 3);
         w1 = (k % 15 == 0);
         checks++;
         if ({IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1} !== {e0, w0, e1, w1}) begin
            errors++;
            $display("FAIL count k%0d: got %h/%b %h/%b want %h/%b %h/%b", k,
                     IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1, e0, w0, e1, w1);
         end
      end
   endtask

   task automatic test_shadow;
      logic [15:0] ei [6];
      logic        ew [6];
      ei = '{16'd3, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
      ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      load_sync(16'd4, 16'd1);
      @(negedge CLK);
      checks++;
      if (IDX_0_OUT !== 16'd1) begin
         errors++;
         $display("FAIL shadow_pre: got %h want 1", IDX_0_OUT);
      end
      UPDATE_SETTINGS = 1'b1; CYCLE_0 = 16'd5;
      @(negedge CLK);
      checks++;
      if ({IDX_0_OUT, WRAP_0} !== {16'd2, 1'b0}) begin
         errors++;
         $display("FAIL shadow_hold: got %h/%b want 2/0", IDX_0_OUT, WRAP_0);
      end
      CYCLE_0 = 16'd2;
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b0; CYCLE_0 = 16'd7;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge CLK);
         checks++;
         if ({IDX_0_OUT, WRAP_0} !== {ei[i], ew[i]}) begin
            errors++;
            $display("FAIL shadow_seq s%0d: got %h/%b want %h/%b", i, IDX_0_OUT, WRAP_0, ei[i], ew[i]);
         end
      end
   endtask

   task automatic test_zero;
      load_sync(16'd0, 16'd0);
      checks++;
      if ({IDX_0_OUT, WRAP_0} !== {16'd0, 1'b0}) begin
         errors++;
         $display("FAIL zero_sync: got %h/%b want 0/0", IDX_0_OUT, WRAP_0);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checks++;
         if ({IDX_0_OUT, WRAP_0} !== {16'd0, 1'b1}) begin
            errors++;
            $display("FAIL zero_run c%0d: got %h/%b want 0/1", i, IDX_0_OUT, WRAP_0);
         end
      end
   endtask

   task automatic test_sync_wrap;
      load_sync(16'd4, 16'd1);
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b1; CYCLE_0 = 16'd2;
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b0;
      @(negedge CLK);
      checks++;
      if (IDX_0_OUT !== 16'd3) begin
         errors++;
         $display("FAIL sync_wrap_pre: got %h want 3", IDX_0_OUT);
      end
      SYNC = 1'b1;
      @(negedge CLK);
      SYNC = 1'b0;
      checks++;
      if ({IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1} !== 34'd0) begin
         errors++;
         $display("FAIL sync_wins: got %h/%b %h/%b want 0/0 0/0", IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1);
      end
      @(negedge CLK);
      checks++;
      if ({IDX_0_OUT, WRAP_0} !== {16'd1, 1'b0}) begin
         errors++;
         $display("FAIL sync_pend_a: got %h/%b want 1/0", IDX_0_OUT, WRAP_0);
      end
      @(negedge CLK);
      checks++;
      if ({IDX_0_OUT, WRAP_0} !== {16'd0, 1'b1}) begin
         errors++;
         $display("FAIL sync_pend_b: got %h/%b want 0/1", IDX_0_OUT, WRAP_0);
      end
   endtask

   task automatic test_reset_mid;
      load_sync(16'd4, 16'd1);
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b1; CYCLE_0 = 16'd3; FREQ_DIV_0 = 16'd2;
      @(negedge CLK);
      UPDATE_SETTINGS = 1'b0;
      checks++;
      if (IDX_0_OUT !== 16'd2) begin
         errors++;
         $display("FAIL rst_mid_pre: got %h want 2", IDX_0_OUT);
      end
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1} !== 34'd0) begin
         errors++;
         $display("FAIL rst_async: got %h/%b %h/%b want 0/0 0/0", IDX_0_OUT, WRAP_0, IDX_1_OUT, WRAP_1);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++;
         if ({IDX_0_OUT, WRAP_0} !== {16'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_discard c%0d: got %h/%b want 0/1", i, IDX_0_OUT, WRAP_0);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sync_update();
      test_shadow();
      test_zero();
      test_sync_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
